// File: rtl/vram_wr_arb.sv
// VRAM write-port arbiter: round-robin between a host write requester and a
// block-fill engine, issuing at most one registered RAM write per clock.
module vram_wr_arb #(
  parameter int C_DAT_W = 72,
  parameter int C_ADR_W = 10
) (
  input  logic               CK_i,
  input  logic               RST_i,
  input  logic               HREQ_i,
  input  logic [C_ADR_W-1:0] HA_i,
  input  logic [C_DAT_W-1:0] HD_i,
  output logic               HACK_o,
  input  logic               FILL_START_i,
  input  logic [C_ADR_W-1:0] FILL_BASE_i,
  input  logic [C_ADR_W:0]   FILL_LEN_i,
  input  logic [C_DAT_W-1:0] FILL_DAT_i,
  input  logic               FILL_ABORT_i,
  output logic               FILL_BUSY_o,
  output logic               FILL_DONE_o,
  output logic               WE_o,
  output logic [C_ADR_W-1:0] WA_o,
  output logic [C_DAT_W-1:0] WD_o
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [C_ADR_W:0] CNT_ONE = {{C_ADR_W{1'b0}}, 1'b1};

  state_t             state;
  state_t             state_nxt;
  logic [C_ADR_W-1:0] fill_adr;
  logic [C_ADR_W:0]   fill_cnt;
  logic [C_DAT_W-1:0] fill_dat;
  logic               last_fill;
  logic               fill_req;
  logic               grant_host;
  logic               grant_fill;

  // last_fill set means the fill engine won most recently, so the host wins a tie
  always_comb begin
    fill_req   = (state == FILL) && (fill_cnt != '0);
    grant_host = HREQ_i && !RST_i && (!fill_req || last_fill);
    grant_fill = fill_req && !RST_i && (!HREQ_i || !last_fill);
  end

  assign HACK_o      = grant_host;
  assign FILL_BUSY_o = (state == FILL);
  assign FILL_DONE_o = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (FILL_START_i) state_nxt = (FILL_LEN_i != '0) ? FILL : DONE;
      FILL: if (FILL_ABORT_i || (grant_fill && fill_cnt == CNT_ONE)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state     <= IDLE;
      fill_adr  <= '0;
      fill_cnt  <= '0;
      fill_dat  <= '0;
      last_fill <= 1'b1;
      WE_o      <= 1'b0;
      WA_o      <= '0;
      WD_o      <= '0;
    end else begin
      state <= state_nxt;
      // Fill parameters load only from IDLE; a start pulse mid-fill is ignored
      if (state == IDLE && FILL_START_i) begin
        fill_adr <= FILL_BASE_i;
        fill_cnt <= FILL_LEN_i;
        fill_dat <= FILL_DAT_i;
      end else if (grant_fill) begin
        fill_adr <= fill_adr + 1'b1;
        fill_cnt <= fill_cnt - 1'b1;
      end
      if (grant_host)      last_fill <= 1'b0;
      else if (grant_fill) last_fill <= 1'b1;
      WE_o <= grant_host || grant_fill;
      if (grant_host) begin
        WA_o <= HA_i;
        WD_o <= HD_i;
      end else if (grant_fill) begin
        WA_o <= fill_adr;
        WD_o <= fill_dat;
      end
    end
  end

endmodule

// File: tb/tb_vram_wr_arb.sv
// Self-checking bench for vram_wr_arb: directed scenarios plus random traffic,
// all compared against a queue-based behavioural model of the write stream.
module tb_vram_wr_arb;

  localparam int DW    = 72;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          CK_i = 1'b0;
  logic          RST_i, HREQ_i, HACK_o;
  logic [AW-1:0] HA_i, FILL_BASE_i, WA_o;
  logic [DW-1:0] HD_i, FILL_DAT_i, WD_o;
  logic [AW:0]   FILL_LEN_i;
  logic          FILL_START_i, FILL_ABORT_i, FILL_BUSY_o, FILL_DONE_o, WE_o;

  always #5 CK_i = ~CK_i;

  vram_wr_arb #(.C_DAT_W(DW), .C_ADR_W(AW)) dut (
    .CK_i(CK_i), .RST_i(RST_i), .HREQ_i(HREQ_i), .HA_i(HA_i), .HD_i(HD_i),
    .HACK_o(HACK_o), .FILL_START_i(FILL_START_i), .FILL_BASE_i(FILL_BASE_i),
    .FILL_LEN_i(FILL_LEN_i), .FILL_DAT_i(FILL_DAT_i), .FILL_ABORT_i(FILL_ABORT_i),
    .FILL_BUSY_o(FILL_BUSY_o), .FILL_DONE_o(FILL_DONE_o),
    .WE_o(WE_o), .WA_o(WA_o), .WD_o(WD_o)
  );

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 filling, 2 done; fq holds the fill addresses still owed
  int            mph;
  int            fq[$];
  logic [DW-1:0] mdat;
  logic          mlast;
  logic          exp_we;
  logic [AW-1:0] exp_wa;
  logic [DW-1:0] exp_wd;
  logic          m_gh, m_gf;
  int            wr_log[$];
  int            done_cnt;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic hreq, input logic [AW-1:0] ha,
                               input logic [DW-1:0] hd, input logic start,
                               input logic [AW-1:0] base, input logic [AW:0] len,
                               input logic [DW-1:0] dat, input logic abort);
    logic fp;
    RST_i = rst; HREQ_i = hreq; HA_i = ha; HD_i = hd;
    FILL_START_i = start; FILL_BASE_i = base; FILL_LEN_i = len;
    FILL_DAT_i = dat; FILL_ABORT_i = abort;
    #1;
    fp   = (mph == 1) && (fq.size() > 0);
    m_gh = hreq && !rst && (!fp || mlast);
    m_gf = fp && !rst && (!hreq || !mlast);
    checkOutput("hack", HACK_o, m_gh);
    @(posedge CK_i);
    if (rst) begin
      mph = 0; fq.delete(); mdat = '0; mlast = 1'b1;
      exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
    end else begin
      if (m_gh) begin
        exp_we = 1'b1; exp_wa = ha; exp_wd = hd; mlast = 1'b0;
      end else if (m_gf) begin
        exp_we = 1'b1; exp_wa = AW'(fq[0]); exp_wd = mdat; mlast = 1'b1;
      end else begin
        exp_we = 1'b0;
      end
      case (mph)
        0: if (start) begin
             fq.delete();
             for (int i = 0; i < int'(len); i++) fq.push_back((int'(base) + i) % DEPTH);
             mdat = dat;
             mph  = (len != 0) ? 1 : 2;
           end
        1: begin
             if (m_gf) void'(fq.pop_front());
             if (abort || (m_gf && fq.size() == 0)) mph = 2;
           end
        default: mph = 0;
      endcase
    end
    @(negedge CK_i);
    checkOutput("we", WE_o, exp_we);
    checkOutput("wa", WA_o, exp_wa);
    checkOutput("wd", WD_o, exp_wd);
    checkOutput("busy", FILL_BUSY_o, mph == 1);
    checkOutput("done", FILL_DONE_o, mph == 2);
    if (WE_o === 1'b1) wr_log.push_back(int'(WA_o));
    if (FILL_DONE_o === 1'b1) done_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, '0, '0, '0, 0);
  endtask

  task automatic startFill(input logic [AW-1:0] base, input logic [AW:0] len, input logic [DW-1:0] dat);
    applyStimulus(0, 0, '0, '0, 1, base, len, dat, 0);
  endtask

  task automatic doReset();
    applyStimulus(1, 1, 10'h2A, 72'h5, 0, '0, '0, '0, 0);
    wr_log.delete();
    done_cnt = 0;
  endtask

  initial begin
    int host_idx;
    int seen[DEPTH];
    int once;
    logic [AW-1:0] fbase;
    logic          hpend;
    logic [AW-1:0] rha;
    logic [DW-1:0] rhd;

    mph = 0; mlast = 1'b1; mdat = '0; exp_we = 0; exp_wa = '0; exp_wd = '0; done_cnt = 0;
    doReset();
    doReset();

    // Host only
    applyStimulus(0, 1, 10'd5, 72'hAB, 0, '0, '0, '0, 0);
    idle(1);
    checkOutput("host_wr_cnt", wr_log.size(), 1);
    if (wr_log.size() > 0) checkOutput("host_wr_adr", wr_log[0], 5);

    // Fill with address wrap
    doReset();
    startFill(10'h3FE, 11'd4, 72'h11);
    idle(6);
    checkOutput("wrap_cnt", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      checkOutput("wrap_a0", wr_log[0], 'h3FE);
      checkOutput("wrap_a1", wr_log[1], 'h3FF);
      checkOutput("wrap_a2", wr_log[2], 'h000);
      checkOutput("wrap_a3", wr_log[3], 'h001);
    end
    checkOutput("wrap_done_cnt", done_cnt, 1);

    // Contention: host and fill alternate, host first
    doReset();
    startFill(10'h040, 11'd3, 72'h77);
    host_idx = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, host_idx < 3, AW'(10'h100 + host_idx), 72'h9, 0, '0, '0, '0, 0);
      if (m_gh) host_idx++;
    end
    checkOutput("rr_cnt", wr_log.size(), 6);
    if (wr_log.size() == 6) begin
      checkOutput("rr_0", wr_log[0], 'h100);
      checkOutput("rr_1", wr_log[1], 'h040);
      checkOutput("rr_2", wr_log[2], 'h101);
      checkOutput("rr_3", wr_log[3], 'h041);
      checkOutput("rr_4", wr_log[4], 'h102);
      checkOutput("rr_5", wr_log[5], 'h042);
    end

    // Start pulse during FILL is ignored
    doReset();
    startFill(10'h010, 11'd4, 72'h22);
    startFill(10'h200, 11'd2, 72'h33);
    idle(5);
    checkOutput("ign_cnt", wr_log.size(), 4);
    if (wr_log.size() == 4) checkOutput("ign_last", wr_log[3], 'h013);

    // Zero length
    doReset();
    startFill(10'h055, 11'd0, 72'h44);
    idle(3);
    checkOutput("zero_wr_cnt", wr_log.size(), 0);
    checkOutput("zero_done_cnt", done_cnt, 1);

    // Abort coinciding with the second fill grant
    doReset();
    startFill(10'h080, 11'd5, 72'h55);
    idle(1);
    applyStimulus(0, 0, '0, '0, 0, '0, '0, '0, 1);
    idle(3);
    checkOutput("abort_wr_cnt", wr_log.size(), 2);
    checkOutput("abort_done_cnt", done_cnt, 1);

    // Reset during FILL
    doReset();
    startFill(10'h0C0, 11'd8, 72'h66);
    idle(2);
    applyStimulus(1, 0, '0, '0, 0, '0, '0, '0, 0);
    idle(3);
    checkOutput("rst_wr_cnt", wr_log.size(), 2);
    checkOutput("rst_done_cnt", done_cnt, 0);

    // Full-depth fill touches every address exactly once
    doReset();
    fbase = AW'($urandom_range(0, DEPTH - 1));
    startFill(fbase, 11'(DEPTH), {$urandom, $urandom, $urandom});
    idle(DEPTH + 4);
    checkOutput("full_cnt", wr_log.size(), DEPTH);
    if (wr_log.size() > 0) checkOutput("full_first", wr_log[0], int'(fbase));
    for (int i = 0; i < DEPTH; i++) seen[i] = 0;
    foreach (wr_log[i]) seen[wr_log[i]]++;
    once = 0;
    for (int i = 0; i < DEPTH; i++) if (seen[i] == 1) once++;
    checkOutput("full_once", once, DEPTH);

    // Random traffic against the model
    doReset();
    hpend = 1'b0; rha = '0; rhd = '0;
    for (int c = 0; c < 3000; c++) begin
      logic st, ab, rs;
      if (!hpend && $urandom_range(0, 1) == 1) begin
        hpend = 1'b1;
        rha = AW'($urandom);
        rhd = {$urandom, $urandom, $urandom};
      end
      st = ($urandom_range(0, 19) == 0);
      ab = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 199) == 0);
      applyStimulus(rs, hpend, rha, rhd, st, AW'($urandom),
                    11'($urandom_range(0, 6)), {$urandom, $urandom, $urandom}, ab);
      if (m_gh) hpend = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
